// File: rtl/boot_pkg.sv
`default_nettype none
// boot_pkg: FSM states, SPI opcode and error codes shared by the flash boot loader.
// Rev 1.0
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_HDR   = 3'd3,
    ST_DATA  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } boot_state_e;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/boot_byte_seq.sv
`default_nettype none
// boot_byte_seq: one-byte ISSUE/WAIT handshake towards the SPI byte engine, with per-byte timeout.
// Rev 1.0
module boot_byte_seq
  import boot_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_req,
  input  logic [7:0] tx_byte,
  output logic       byte_ok,
  output logic       byte_timeout,
  output logic       spi_start_o,
  output logic [7:0] spi_tx_o,
  input  logic       spi_done_i
);

  logic        waiting;
  logic [31:0] wait_cnt;
  logic        limit_hit;

  assign spi_start_o  = byte_req && !waiting;
  assign spi_tx_o     = spi_start_o ? tx_byte : 8'h00;
  assign byte_ok      = waiting && spi_done_i;
  // A done arriving on the limit cycle wins over the timeout.
  assign limit_hit    = (TIMEOUT_CYC != 0) && (wait_cnt == TIMEOUT_CYC - 1);
  assign byte_timeout = waiting && !spi_done_i && limit_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      waiting  <= 1'b0;
      wait_cnt <= '0;
    end else if (spi_start_o) begin
      waiting  <= 1'b1;
      wait_cnt <= '0;
    end else if (waiting) begin
      if (byte_ok || byte_timeout) begin
        waiting <= 1'b0;
      end
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// boot_loader: reads a flash image over SPI into on-chip memory, then releases the cores.
// Rev 1.0
module boot_loader #(
  parameter int          FLASH_ADDR_BYTES = 3,
  parameter logic [31:0] FLASH_BOOT_ADDR  = 32'h0000_0000,
  parameter int          MEM_ADDR_W       = 32,
  parameter logic [31:0] MEM_BASE         = 32'h0000_0000,
  parameter int          MAX_WORDS        = 1024,
  parameter bit          USE_HEADER       = 1'b1,
  parameter int unsigned TIMEOUT_CYC      = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  spi_start_o,
  output logic [7:0]            spi_tx_o,
  input  logic [7:0]            spi_rx_i,
  input  logic                  spi_done_i,
  output logic                  spi_cs_n_o,
  output logic                  mem_valid_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ready_i,
  output logic                  cores_run_o,
  output logic                  boot_err_o,
  output logic [1:0]            err_code_o
);
  import boot_pkg::*;

  localparam int               CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  boot_state_e           state;
  logic [1:0]            byte_idx;
  logic [31:0]           shift_word;
  logic [CNT_W-1:0]      num_words;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      num_total;
  logic [MEM_ADDR_W-1:0] wr_addr;
  logic [1:0]            err_code;
  logic                  byte_req;
  logic                  byte_ok;
  logic                  byte_timeout;
  logic [7:0]            tx_byte;
  logic [31:0]           rx_word;
  logic [31:0]           boot_addr;
  logic [1:0]            addr_sel;
  logic                  last_addr;
  logic                  bad_len;

  boot_byte_seq #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte_seq (
    .clk          (clk),
    .reset        (reset),
    .byte_req     (byte_req),
    .tx_byte      (tx_byte),
    .byte_ok      (byte_ok),
    .byte_timeout (byte_timeout),
    .spi_start_o  (spi_start_o),
    .spi_tx_o     (spi_tx_o),
    .spi_done_i   (spi_done_i)
  );

  // Bytes arrive LSB first, so each new byte shifts in at the top.
  assign rx_word   = {spi_rx_i, shift_word[31:8]};
  assign byte_req  = state inside {ST_CMD, ST_ADDR, ST_HDR, ST_DATA};
  assign boot_addr = FLASH_BOOT_ADDR;
  assign addr_sel  = 2'(FLASH_ADDR_BYTES - 1 - int'(byte_idx));
  assign last_addr = (int'(byte_idx) == FLASH_ADDR_BYTES - 1);
  assign bad_len   = (rx_word == 32'd0) || (rx_word > 32'(MAX_WORDS));
  assign num_total = USE_HEADER ? num_words : MAX_N;

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      ST_CMD:  tx_byte = SPI_CMD_READ;
      ST_ADDR: tx_byte = boot_addr[{addr_sel, 3'b000} +: 8];
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      byte_idx   <= '0;
      shift_word <= '0;
      num_words  <= '0;
      word_cnt   <= '0;
      wr_addr    <= MEM_ADDR_W'(MEM_BASE);
      err_code   <= ERR_NONE;
    end else if (byte_timeout) begin
      state    <= ST_ERROR;
      err_code <= ERR_TIMEOUT;
    end else begin
      case (state)
        ST_IDLE: state <= ST_CMD;
        ST_CMD: begin
          if (byte_ok) begin
            state    <= ST_ADDR;
            byte_idx <= '0;
          end
        end
        ST_ADDR: begin
          if (byte_ok) begin
            byte_idx <= byte_idx + 2'd1;
            if (last_addr) begin
              byte_idx <= '0;
              state    <= USE_HEADER ? ST_HDR : ST_DATA;
            end
          end
        end
        ST_HDR: begin
          if (byte_ok) begin
            shift_word <= rx_word;
            byte_idx   <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (bad_len) begin
                state    <= ST_ERROR;
                err_code <= ERR_LEN;
              end else begin
                num_words <= CNT_W'(rx_word);
                state     <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (byte_ok) begin
            shift_word <= rx_word;
            byte_idx   <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready_i) begin
            word_cnt <= word_cnt + 1'b1;
            wr_addr  <= wr_addr + MEM_ADDR_W'(4);
            state    <= (word_cnt + 1'b1 == num_total) ? ST_DONE : ST_DATA;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign spi_cs_n_o  = !(state inside {ST_CMD, ST_ADDR, ST_HDR, ST_DATA, ST_WRITE});
  assign mem_valid_o = (state == ST_WRITE);
  assign mem_addr_o  = mem_valid_o ? wr_addr : '0;
  assign mem_wdata_o = mem_valid_o ? shift_word : 32'd0;
  assign cores_run_o = (state == ST_DONE);
  assign boot_err_o  = (state == ST_ERROR);
  assign err_code_o  = err_code;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// tb_boot_loader: directed vectors for the flash boot loader across two parameter sets.
// Rev 1.0
module tb_boot_loader;

  localparam logic [31:0] A_FLASH = 32'h0001_0000;
  localparam logic [31:0] A_BASE  = 32'h2000_0000;
  localparam logic [31:0] B_FLASH = 32'hA1B2_C3D4;
  localparam logic [31:0] B_BASE  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, rst_b;
  logic [7:0] spi_rx;
  logic       spi_done;
  logic       mem_ready;
  bit         sel;

  logic        start_a, cs_n_a, valid_a, run_a, err_a;
  logic [7:0]  tx_a;
  logic [31:0] addr_a, wdata_a;
  logic [1:0]  code_a;
  logic        start_b, cs_n_b, valid_b, run_b, err_b;
  logic [7:0]  tx_b;
  logic [31:0] addr_b, wdata_b;
  logic [1:0]  code_b;

  boot_loader #(
    .FLASH_ADDR_BYTES (3), .FLASH_BOOT_ADDR (A_FLASH), .MEM_ADDR_W (32),
    .MEM_BASE (A_BASE), .MAX_WORDS (8), .USE_HEADER (1'b1), .TIMEOUT_CYC (10)
  ) dut_a (
    .clk (clk), .reset (rst_a), .spi_start_o (start_a), .spi_tx_o (tx_a),
    .spi_rx_i (spi_rx), .spi_done_i (spi_done), .spi_cs_n_o (cs_n_a),
    .mem_valid_o (valid_a), .mem_addr_o (addr_a), .mem_wdata_o (wdata_a),
    .mem_ready_i (mem_ready), .cores_run_o (run_a), .boot_err_o (err_a),
    .err_code_o (code_a)
  );

  boot_loader #(
    .FLASH_ADDR_BYTES (4), .FLASH_BOOT_ADDR (B_FLASH), .MEM_ADDR_W (32),
    .MEM_BASE (B_BASE), .MAX_WORDS (4), .USE_HEADER (1'b0), .TIMEOUT_CYC (10)
  ) dut_b (
    .clk (clk), .reset (rst_b), .spi_start_o (start_b), .spi_tx_o (tx_b),
    .spi_rx_i (spi_rx), .spi_done_i (spi_done), .spi_cs_n_o (cs_n_b),
    .mem_valid_o (valid_b), .mem_addr_o (addr_b), .mem_wdata_o (wdata_b),
    .mem_ready_i (mem_ready), .cores_run_o (run_b), .boot_err_o (err_b),
    .err_code_o (code_b)
  );

  // The idle DUT is always held in reset, so shared inputs are harmless.
  logic        start_s, cs_n_s, valid_s, run_s, err_s;
  logic [7:0]  tx_s;
  logic [31:0] addr_s, wdata_s;
  logic [1:0]  code_s;
  assign start_s = sel ? start_b : start_a;
  assign cs_n_s  = sel ? cs_n_b  : cs_n_a;
  assign valid_s = sel ? valid_b : valid_a;
  assign run_s   = sel ? run_b   : run_a;
  assign err_s   = sel ? err_b   : err_a;
  assign tx_s    = sel ? tx_b    : tx_a;
  assign addr_s  = sel ? addr_b  : addr_a;
  assign wdata_s = sel ? wdata_b : wdata_a;
  assign code_s  = sel ? code_b  : code_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Flash/SPI-engine and memory model state.
  logic [7:0]  rx_mem [0:63];
  logic [7:0]  tx_log [0:63];
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int nbytes, nwr, pend, cur, model_delay, withhold, start_cyc, err_cyc;
  bit valid_seen, cs_bad;

  task automatic clear_model();
    nbytes = 0; nwr = 0; pend = 0; cur = 0; start_cyc = -1; err_cyc = -1;
    valid_seen = 1'b0; cs_bad = 1'b0; spi_done = 1'b0; withhold = -1;
    for (int i = 0; i < 64; i++) tx_log[i] = 8'hEE;
  endtask

  initial begin : bus_model
    forever begin
      @(negedge clk);
      #1;
      spi_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          spi_done = 1'b1;
          spi_rx   = rx_mem[cur];
        end
      end
      if (start_s) begin
        if (nbytes < 64) tx_log[nbytes] = tx_s;
        if (cs_n_s) cs_bad = 1'b1;
        cur = (nbytes < 64) ? nbytes : 63;
        if (nbytes == withhold) start_cyc = cyc;
        else pend = model_delay;
        nbytes++;
      end
      if (valid_s) begin
        valid_seen = 1'b1;
        if (mem_ready && nwr < 16) begin
          wr_addr[nwr] = addr_s;
          wr_data[nwr] = wdata_s;
          nwr++;
        end
      end
      if (err_s && err_cyc < 0) err_cyc = cyc;
    end
  end

  function automatic logic [31:0] word_of(input logic [31:0] w0, input logic [31:0] w1, input int i);
    return (i == 0) ? w0 : (i == 1) ? w1 : w1 + 32'(i);
  endfunction

  task automatic load_rx(input logic [31:0] hdr, input logic [31:0] w0, input logic [31:0] w1,
                         input bit use_hdr, input int ab);
    int pos;
    logic [31:0] w;
    pos = 1 + ab;
    for (int i = 0; i < 64; i++) rx_mem[i] = 8'h00;
    if (use_hdr) begin
      for (int b = 0; b < 4; b++) rx_mem[pos + b] = hdr[8*b +: 8];
      pos = pos + 4;
    end
    for (int k = 0; k < 8; k++) begin
      w = word_of(w0, w1, k);
      for (int b = 0; b < 4; b++) rx_mem[pos + 4*k + b] = w[8*b +: 8];
    end
  endtask

  task automatic start_run(input bit s, input int delay, input int hold);
    sel = s; rst_a = 1'b1; rst_b = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    clear_model();
    model_delay = delay;
    withhold    = hold;
    if (s) rst_b = 1'b0;
    else   rst_a = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int i;
    i = 0;
    while (!(run_s || err_s) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("boot_finished", 64'(run_s || err_s), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {start_s, cs_n_s, valid_s, run_s, err_s, code_s, tx_s},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00});
    check({tag, "_addr"}, addr_s, 64'd0);
    check({tag, "_wdata"}, wdata_s, 64'd0);
  endtask

  task automatic check_tx(input int nexp, input logic [31:0] fa, input int ab);
    logic [7:0]  got, want, e;
    logic [31:0] sh;
    int idx;
    bit found;
    check("tx_count", 64'(nbytes), 64'(nexp));
    got = tx_log[0]; want = 8'h03; idx = 0; found = 1'b0;
    for (int i = 0; i < nexp && i < 64; i++) begin
      if (i == 0) e = 8'h03;
      else if (i <= ab) begin
        sh = fa >> (8 * (ab - i));
        e  = sh[7:0];
      end else e = 8'h00;
      if (!found && tx_log[i] !== e) begin
        found = 1'b1; got = tx_log[i]; want = e; idx = i;
      end
    end
    check($sformatf("tx_byte%0d", idx), 64'(got), 64'(want));
  endtask

  task automatic check_writes(input int nexp, input logic [31:0] base,
                              input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] got, want;
    int idx;
    bit found;
    check("write_count", 64'(nwr), 64'(nexp));
    if (nexp > 0 && nwr > 0) begin
      got = {wr_addr[0], wr_data[0]}; want = {base, w0}; idx = 0; found = 1'b0;
      for (int i = 0; i < nexp && i < nwr; i++) begin
        if (!found && {wr_addr[i], wr_data[i]} !== {base + 32'(4 * i), word_of(w0, w1, i)}) begin
          found = 1'b1; idx = i;
          got  = {wr_addr[i], wr_data[i]};
          want = {base + 32'(4 * i), word_of(w0, w1, i)};
        end
      end
      check($sformatf("write%0d_addr_data", idx), got, want);
    end
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] w0;
    logic [31:0] w1;
    int          delay;
    bit          exp_err;
    logic [1:0]  exp_code;
    int          exp_writes;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int          guard;
    int          bad;
    logic [31:0] a0, d0;

    vecs[0] = '{32'd2,          32'h1122_3344, 32'hAABB_CCDD,  1, 1'b0, 2'd0, 2};
    vecs[1] = '{32'd0,          32'h1111_1111, 32'h2222_2222,  1, 1'b1, 2'd2, 0};
    vecs[2] = '{32'd9,          32'h1111_1111, 32'h2222_2222,  2, 1'b1, 2'd2, 0};
    vecs[3] = '{32'h0001_0001,  32'h1111_1111, 32'h2222_2222,  1, 1'b1, 2'd2, 0};
    vecs[4] = '{32'd8,          32'h0102_0304, 32'h0506_0708,  3, 1'b0, 2'd0, 8};
    vecs[5] = '{32'd1,          32'hDEAD_BEEF, 32'h0000_0000, 10, 1'b0, 2'd0, 1};
    vecs[6] = '{32'h8000_0003,  32'h1111_1111, 32'h2222_2222,  1, 1'b1, 2'd2, 0};

    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0; spi_rx = 8'h00; mem_ready = 1'b1;
    model_delay = 1;
    clear_model();
    repeat (3) @(negedge clk);
    check_reset("reset_a");

    for (int v = 0; v < 7; v++) begin
      load_rx(vecs[v].hdr, vecs[v].w0, vecs[v].w1, 1'b1, 3);
      start_run(1'b0, vecs[v].delay, -1);
      wait_end(3000);
      check_tx(8 + 4 * vecs[v].exp_writes, A_FLASH, 3);
      check_writes(vecs[v].exp_writes, A_BASE, vecs[v].w0, vecs[v].w1);
      check($sformatf("vec%0d_status", v), {run_s, err_s, code_s, cs_n_s},
            {~vecs[v].exp_err, vecs[v].exp_err, vecs[v].exp_code, 1'b1});
      check($sformatf("vec%0d_valid_seen", v), 64'(valid_seen), 64'(vecs[v].exp_writes > 0));
      check($sformatf("vec%0d_cs_low_on_start", v), 64'(cs_bad), 64'd0);
    end

    // Second address byte never completes.
    load_rx(32'd2, 32'h1122_3344, 32'hAABB_CCDD, 1'b1, 3);
    start_run(1'b0, 1, 2);
    wait_end(500);
    check("timeout_latency", 64'(err_cyc - start_cyc), 64'd11);
    check("timeout_status", {run_s, err_s, code_s, cs_n_s}, {1'b0, 1'b1, 2'd1, 1'b1});
    check("timeout_bytes", 64'(nbytes), 64'd3);

    // Memory back-pressure on word 0.
    load_rx(32'd2, 32'h1122_3344, 32'hAABB_CCDD, 1'b1, 3);
    start_run(1'b0, 1, -1);
    mem_ready = 1'b0;
    guard = 0;
    while (!valid_s && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("stall_reach_write", 64'(valid_s), 64'd1);
    a0 = addr_s; d0 = wdata_s; bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (addr_s !== a0 || wdata_s !== d0 || start_s !== 1'b0 || valid_s !== 1'b1) bad++;
    end
    check("stall_stable", 64'(bad), 64'd0);
    check("stall_word0", {a0, d0}, {A_BASE, 32'h1122_3344});
    mem_ready = 1'b1;
    wait_end(1000);
    check_writes(2, A_BASE, 32'h1122_3344, 32'hAABB_CCDD);
    check("stall_status", {run_s, err_s, code_s, cs_n_s}, {1'b1, 1'b0, 2'd0, 1'b1});

    // Reset pulse while word 1 is being read.
    load_rx(32'd2, 32'h1122_3344, 32'hAABB_CCDD, 1'b1, 3);
    start_run(1'b0, 1, -1);
    guard = 0;
    while (!(nwr >= 1 && nbytes >= 14) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_word1", 64'(nwr >= 1 && nbytes >= 14), 64'd1);
    rst_a = 1'b1;
    @(negedge clk);
    check_reset("reset_mid");
    clear_model();
    model_delay = 1;
    rst_a = 1'b0;
    wait_end(1000);
    check_tx(16, A_FLASH, 3);
    check_writes(2, A_BASE, 32'h1122_3344, 32'hAABB_CCDD);
    check("restart_status", {run_s, err_s, code_s, cs_n_s}, {1'b1, 1'b0, 2'd0, 1'b1});

    // Headerless build, 4-byte address, write address wraps past 2^32.
    sel = 1'b1;
    @(negedge clk);
    check_reset("reset_b");
    load_rx(32'd0, 32'hCAFE_F00D, 32'h0123_4567, 1'b0, 4);
    start_run(1'b1, 2, -1);
    wait_end(1000);
    check_tx(21, B_FLASH, 4);
    check_writes(4, B_BASE, 32'hCAFE_F00D, 32'h0123_4567);
    check("nohdr_status", {run_s, err_s, code_s, cs_n_s}, {1'b1, 1'b0, 2'd0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Parametrised successor of the single-word flash boot sequencer.
- After reset, issues an SPI READ (0x03) at a configurable flash address and streams N 32-bit words into on-chip memory through a valid/ready write port.
- Releases the cores once the copy completes.
- Adds three features over the single-word sequencer: configurable address width, an optional length header, and a per-byte SPI timeout with error reporting.

Parameters:
- FLASH_ADDR_BYTES, 3, number of address bytes sent after the command (3 or 4).
- FLASH_BOOT_ADDR, 32'h0000_0000, flash start address; low FLASH_ADDR_BYTES*8 bits are sent MSB byte first.
- MEM_ADDR_W, 32, width of the memory write address.
- MEM_BASE, 32'h0000_0000, memory address of the first word written.
- MAX_WORDS, 1024, upper bound on words copied.
- USE_HEADER, 1, 1: first flash word is the word count N; 0: N = MAX_WORDS, no header.
- TIMEOUT_CYC, 65535, max cycles waiting for spi_done_i per byte; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_start_o  out  1  one-cycle pulse: byte engine transmits spi_tx_o
- spi_tx_o  out  8  byte to transmit; valid when spi_start_o = 1
- spi_rx_i  in  8  received byte; valid when spi_done_i = 1
- spi_done_i  in  1  one-cycle pulse: byte transfer complete
- spi_cs_n_o  out  1  flash chip select, active low
- mem_valid_o  out  1  write request
- mem_addr_o  out  MEM_ADDR_W  byte address of the write
- mem_wdata_o  out  32  write data
- mem_ready_i  in  1  write accepted when mem_valid_o && mem_ready_i
- cores_run_o  out  1  cores released; level
- boot_err_o  out  1  boot failed; level
- err_code_o  out  2  0 = none, 1 = SPI timeout, 2 = bad length

Behaviour:
- Reset:
  - While reset = 1, all outputs are 0 except spi_cs_n_o = 1.
  - State is IDLE; counters clear.
  - Reset asserted mid-operation aborts immediately, with the same values, on the next edge.
- Byte protocol:
  - Each byte is one ISSUE cycle (spi_start_o = 1, spi_tx_o driven), then WAIT until spi_done_i.
  - The next ISSUE is the cycle after done.
  - spi_done_i is ignored outside WAIT.
  - spi_tx_o = 8'h00 for all read bytes.
- States:
  - IDLE: one cycle after reset release, then CMD. spi_cs_n_o = 1.
  - CMD: send 8'h03. spi_cs_n_o drops to 0 in the same cycle as the first spi_start_o.
  - ADDR: FLASH_ADDR_BYTES bytes, most-significant byte first.
  - HDR: only if USE_HEADER. Reads 4 bytes, assembled little-endian (first byte into [7:0]).
    - N = 0 or N > MAX_WORDS gives ERROR, code 2.
  - DATA: 4 bytes per word, little-endian, then WRITE.
  - WRITE:
    - mem_valid_o = 1, mem_addr_o = MEM_BASE + 4*k for word k.
    - mem_wdata_o holds stable until ready.
    - On the handshake: k++. If k == N, go to DONE; otherwise return to DATA.
    - No SPI byte is issued while in WRITE.
    - Waiting on mem_ready_i has no timeout.
  - DONE:
    - spi_cs_n_o = 1 and cores_run_o = 1, from the first DONE cycle.
    - Terminal until reset.
  - ERROR:
    - spi_cs_n_o = 1 and boot_err_o = 1; err_code_o holds the cause.
    - cores_run_o stays 0.
    - Terminal until reset.
- Timeout:
  - The counter clears on every ISSUE and increments in WAIT.
  - Reaching TIMEOUT_CYC without done gives ERROR, code 1.
  - spi_done_i in the same cycle the counter reaches TIMEOUT_CYC counts as success.
- Width rules:
  - The word counter is clog2(MAX_WORDS+1) bits.
  - The header comparison uses the full 32 bits, so an N with upper bits set is rejected.
  - mem_addr_o wraps modulo 2^MEM_ADDR_W.
- Total SPI bytes for a successful boot: 1 + FLASH_ADDR_BYTES + 4*USE_HEADER + 4*N.

Decomposition:
- Package boot_pkg holds:
  - the state enum boot_state_e (IDLE, CMD, ADDR, HDR, DATA, WRITE, DONE, ERROR);
  - the constant SPI_CMD_READ = 8'h03;
  - the error codes ERR_NONE, ERR_TIMEOUT, ERR_LEN.
- One sub-module, boot_byte_seq, owns the ISSUE/WAIT handshake and the timeout counter.
  - It gives the top-level FSM a "byte_req/byte_ok/byte_timeout" interface.
  - Everything else lives in boot_loader.

Test Plan:
- USE_HEADER = 1, FLASH_BOOT_ADDR = 24'h01_0000:
  - Stimulus: header N = 2, data 0x11223344 and 0xAABBCCDD, bytes supplied LSB first.
  - Required response:
    - tx sequence 03,01,00,00, then 00 for all read bytes;
    - writes (MEM_BASE, 0x11223344) and (MEM_BASE+4, 0xAABBCCDD);
    - cores_run_o = 1 after the second handshake; cs_n = 1.
- Header N = 0, then separately N = MAX_WORDS+1:
  - boot_err_o = 1 and err_code_o = 2, with no mem_valid_o ever asserted.
  - Header N = 32'h0001_0001 is rejected the same way.
- TIMEOUT_CYC = 10, withhold spi_done_i during ADDR byte 1:
  - ERROR, code 1, exactly 10 WAIT cycles after that ISSUE.
  - cs_n = 1; cores_run_o = 0.
- mem_ready_i held low for 50 cycles on word 0:
  - mem_addr_o and mem_wdata_o are stable throughout; spi_start_o = 0 throughout.
  - Boot completes normally once ready rises.
- reset = 1 pulsed during DATA word 1:
  - All outputs go to reset values next edge.
  - The full sequence restarts with CMD 03, and mem_addr_o restarts at MEM_BASE.
- USE_HEADER = 0, MAX_WORDS = 4, FLASH_ADDR_BYTES = 4:
  - tx sequence is 03 followed by 4 address bytes.
  - 16 data bytes produce 4 writes, then DONE.
